// File: rtl/alu_operand_collector.sv
// alu_operand_collector: assembles ALU operands/commands from a valid/ready stream and issues one operation per window
module alu_operand_collector #(
  parameter int WIDTH       = 8,
  parameter int CMD_W       = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int ISSUE_GAP   = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             IN_SEL,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_SINGLE,
  input  logic [CMD_W-1:0] IN_CMD,
  input  logic             IN_MODE,
  input  logic             IN_CIN,
  output logic [WIDTH-1:0] OPA,
  output logic [WIDTH-1:0] OPB,
  output logic [CMD_W-1:0] CMD,
  output logic             MODE,
  output logic             CIN,
  output logic             CE,
  output logic [1:0]       INP_VALID,
  output logic             TIMEOUT,
  output logic             BUSY
);
  localparam int CNT_W = $clog2((TIMEOUT_CYC > ISSUE_GAP ? TIMEOUT_CYC : ISSUE_GAP) + 1);
  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, GAP} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [1:0] vld, sel_bit;
  logic to_flag, acc, complete, expire;
  assign sel_bit   = IN_SEL ? 2'b10 : 2'b01;
  assign IN_READY  = !RST && CE && (state == IDLE || state == WAIT);
  assign acc       = IN_VALID && IN_READY;
  assign complete  = acc && state == WAIT && (vld | sel_bit) == 2'b11;
  assign expire    = state == WAIT && CE && cnt == CNT_W'(TIMEOUT_CYC - 1);
  assign INP_VALID = state == ISSUE ? vld : 2'b00;
  assign TIMEOUT   = state == ISSUE && to_flag;
  assign BUSY      = state != IDLE;
  // State register
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_n;
  // Next state: a completing beat beats a timer expiring in the same cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = acc ? (IN_SINGLE ? ISSUE : WAIT) : IDLE;
      WAIT:    state_n = (complete || expire) ? ISSUE : WAIT;
      ISSUE:   state_n = GAP;
      GAP:     state_n = cnt == '0 ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  // Operand slots, command capture on the first beat, timer/gap counter
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      OPA     <= '0;
      OPB     <= '0;
      CMD     <= '0;
      MODE    <= 1'b0;
      CIN     <= 1'b0;
      CE      <= 1'b0;
      vld     <= 2'b00;
      to_flag <= 1'b0;
      cnt     <= '0;
    end else begin
      CE      <= ENABLE;
      to_flag <= expire && !complete;
      cnt     <= state == WAIT ? (CE ? cnt + 1'b1 : cnt) :
                 state == ISSUE ? CNT_W'(ISSUE_GAP - 1) :
                 state == GAP && cnt != '0 ? cnt - 1'b1 : '0;
      OPA     <= !acc ? OPA : !IN_SEL ? IN_DATA : state == IDLE ? '0 : OPA;
      OPB     <= !acc ? OPB : IN_SEL ? IN_DATA : state == IDLE ? '0 : OPB;
      CMD     <= acc && state == IDLE ? IN_CMD : CMD;
      MODE    <= acc && state == IDLE ? IN_MODE : MODE;
      CIN     <= acc && state == IDLE ? IN_CIN : CIN;
      vld     <= !acc ? vld : state == IDLE ? sel_bit : vld | sel_bit;
    end
endmodule

// File: doc/alu_operand_collector.md
Name: alu_operand_collector

Overview:
- Sits directly upstream of the ALU datapath.
- Accepts operands and commands one beat at a time over a valid/ready stream, where OPA and OPB may arrive on different cycles.
- Assembles one complete ALU operation and drives the ALU input bus (OPA, OPB, CMD, MODE, CIN, CE, INP_VALID) for exactly one issue cycle.
- Enforces a collection timeout and an inter-issue gap that covers the ALU's multi-cycle commands.

Parameters:
- WIDTH, 8: operand width (OPA/OPB).
- CMD_W, 4: command width.
- TIMEOUT, 16: cycles allowed between the first and second operand.
- ISSUE_GAP, 3: idle cycles forced after each issue before the next beat is accepted (≥1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  global enable; registered and driven out as CE.
- IN_VALID  in  1  input beat valid.
- IN_READY  out  1  collector can accept a beat.
- IN_SEL  in  1  0 = beat carries OPA, 1 = beat carries OPB.
- IN_DATA  in  WIDTH  operand value.
- IN_SINGLE  in  1  operation needs only this operand; issue immediately.
- IN_CMD  in  CMD_W  command, sampled with the first beat of an operation.
- IN_MODE  in  1  1 = arithmetic, 0 = logical; sampled with the first beat.
- IN_CIN  in  1  carry-in; sampled with the first beat.
- OPA  out  WIDTH  operand A to ALU.
- OPB  out  WIDTH  operand B to ALU.
- CMD  out  CMD_W  command to ALU.
- MODE  out  1  mode to ALU.
- CIN  out  1  carry-in to ALU.
- CE  out  1  ALU clock enable (ENABLE delayed one cycle).
- INP_VALID  out  2  bit0 = OPA valid, bit1 = OPB valid; non-zero only in the issue cycle.
- TIMEOUT  out  1  one-cycle pulse when a partial operation is issued on timeout.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, RST=1): all outputs 0 (OPA, OPB, CMD, MODE, CIN, CE, INP_VALID, TIMEOUT, BUSY); FSM = IDLE; counters = 0. IN_READY is 0 while RST=1.
- Beat transfer: occurs when IN_VALID & IN_READY on a rising edge. IN_READY = 1 in IDLE and WAIT, 0 in ISSUE and GAP.
- CE <= ENABLE every cycle. While CE would be 0 (ENABLE low, registered), IN_READY = 0 and the timeout counter freezes.
- States: IDLE, WAIT, ISSUE, GAP.
- IDLE, beat with IN_SINGLE=1:
  - Latch the operand into the IN_SEL slot; zero the other slot.
  - Latch IN_CMD, IN_MODE, IN_CIN.
  - Set INP_VALID register to 01 (SEL=0) or 10 (SEL=1); go to ISSUE.
- IDLE, beat with IN_SINGLE=0: latch the operand and CMD/MODE/CIN, record which slot is filled, clear the timer, go to WAIT.
- WAIT, beat for the missing slot:
  - Latch it; INP_VALID = 11; go to ISSUE.
  - CMD/MODE/CIN of the second beat are ignored.
- WAIT, beat for an already-filled slot: overwrite that operand, keep waiting; the timer is NOT restarted.
- WAIT, timer reaches TIMEOUT-1 with no completing beat:
  - Go to ISSUE with the partial INP_VALID (01 or 10) and assert the TIMEOUT pulse in the issue cycle.
  - The ALU then flags ERR itself.
  - A completing beat arriving in the same cycle the timer expires wins: full issue, no TIMEOUT.
- ISSUE (exactly one cycle): OPA, OPB, CMD, MODE, CIN, INP_VALID are presented registered. Next state is GAP with counter = ISSUE_GAP-1.
- GAP:
  - INP_VALID = 00; OPA/OPB/CMD hold their last values.
  - Count down to 0, then go to IDLE.
- Latency: from the completing beat edge to INP_VALID≠00 is 1 cycle. Issue rate is at most one operation per 1+ISSUE_GAP cycles after completion.
- Reset asserted mid-WAIT or mid-GAP: operation discarded, outputs return to reset values immediately (async). After deassertion, first acceptance is no earlier than the next rising edge.

Test Plan:
- RST high, then low with ENABLE=1: all outputs 0, IN_READY=1 on the first edge after release; CE=1 one cycle after ENABLE is sampled.
- OPA=8'h0F (SEL=0, CMD=0, MODE=1) at cycle 0, OPB=8'h01 at cycle 3:
  - One cycle later: INP_VALID=11, OPA=0F, OPB=01, CMD=0.
  - Then INP_VALID=00 and IN_READY=0 for 3 cycles.
- IN_SINGLE=1, SEL=1, DATA=8'hAA, CMD=4'h5: next cycle INP_VALID=10, OPB=AA, OPA=00, no TIMEOUT.
- OPA only, no OPB for 16 cycles: INP_VALID=01 and TIMEOUT=1 for one cycle at cycle 16; BUSY stays high through the gap.
- OPB beat in the exact cycle the timer expires: INP_VALID=11, TIMEOUT=0.
- RST pulsed while in WAIT with OPA held: BUSY=0 and INP_VALID=00 immediately; a later lone OPB beat enters WAIT and does not issue.
